// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed request-to-response latency.
// Misaligned or out-of-range requests complete normally but flag rsp_err.
module dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam logic [3:0]  CNT_LOAD = CNT_INIT[3:0];

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // 2-state storage: every word starts at zero in simulation
    bit [63:0]   mem_q [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          acc_write;
    logic [63:0]   acc_addr;
    logic [63:0]   acc_wdata;
    logic [AW-1:0] acc_idx;
    logic          acc_err;

    assign accept     = req_valid && (state_q == IDLE);
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // LATENCY=1 reaches RESP straight from IDLE, so use the live request
    assign acc_write  = (state_q == IDLE) ? req_write : write_q;
    assign acc_addr   = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_wdata  = (state_q == IDLE) ? req_wdata : wdata_q;
    assign acc_idx    = acc_addr[AW+2:3];
    assign acc_err    = (|acc_addr[2:0]) || (|acc_addr[63:AW+3]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid) state_d = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (cnt_q == 4'd0) state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_rdata = rsp_valid ? rdata_q : 64'd0;
        rsp_err   = rsp_valid && err_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            cnt_d   = CNT_LOAD;
            write_d = req_write;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (enter_resp) begin
            err_d   = acc_err;
            rdata_d = (!acc_write && !acc_err) ? mem_q[acc_idx] : 64'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (reset && enter_resp && acc_write && !acc_err) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed vector table, reset-abort and
// LATENCY=1 throughput sequences, then random traffic against a word-map model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;

    logic        req_valid1, req_ready1, req_write1;
    logic [63:0] req_addr1, req_wdata1;
    logic        rsp_valid1, rsp_ready1, rsp_err1;
    logic [63:0] rsp_rdata1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] model [int];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_write(req_write1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    typedef struct {
        bit          w;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          hold;
        logic [63:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit is_err(input logic [63:0] a);
        return (a % 8 != 0) || (a >= 64'(DEPTH) * 8);
    endfunction

    function automatic logic [63:0] peek(input logic [63:0] a);
        int k = int'(a / 8);
        return model.exists(k) ? model[k] : 64'd0;
    endfunction

    task automatic txn(input bit w, input logic [63:0] a, input logic [63:0] d,
                       input int hold, input logic [63:0] exp_rd, input bit exp_err);
        int n;
        chk("idle_ready", req_ready, 1);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 0;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        req_valid = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", n, LAT);
        if (!rsp_valid) return;
        chk("rdata", rsp_rdata, exp_rd);
        chk("err", rsp_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1; req_write = 1; req_addr = 64'h18; req_wdata = '1;
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", rsp_err, exp_err);
            chk("hold_req_ready", req_ready, 0);
        end
        req_valid = 0;
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("post_ready", req_ready, 1);
        chk("post_valid", rsp_valid, 0);
        rsp_ready = 0;
    endtask

    task automatic run_model(input bit w, input logic [63:0] a, input logic [63:0] d,
                             input int hold);
        bit          e  = is_err(a);
        logic [63:0] rd = (!w && !e) ? peek(a) : 64'd0;
        txn(w, a, d, hold, rd, e);
        if (w && !e) model[int'(a / 8)] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [63:0] a, d;
        bit w;
        tbl[0]  = '{1, 64'h10,  64'hDEADBEEF_00000001, 0, 64'd0, 0};
        tbl[1]  = '{0, 64'h10,  64'd0, 0, 64'hDEADBEEF_00000001, 0};
        tbl[2]  = '{1, 64'h08,  64'h1111, 0, 64'd0, 0};
        tbl[3]  = '{0, 64'h0C,  64'd0, 0, 64'd0, 1};
        tbl[4]  = '{0, 64'h800, 64'd0, 0, 64'd0, 1};
        tbl[5]  = '{1, 64'h0C,  64'hBAD, 1, 64'd0, 1};
        tbl[6]  = '{1, 64'h808, 64'hBAD, 0, 64'd0, 1};
        tbl[7]  = '{0, 64'h08,  64'd0, 0, 64'h1111, 0};
        tbl[8]  = '{0, 64'h10,  64'd0, 5, 64'hDEADBEEF_00000001, 0};
        tbl[9]  = '{1, 64'h7F8, 64'hCAFE, 0, 64'd0, 0};
        tbl[10] = '{0, 64'h7F8, 64'd0, 2, 64'hCAFE, 0};
        tbl[11] = '{0, 64'h80000000_00000000, 64'd0, 0, 64'd0, 1};

        rst_n = 0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
        req_valid1 = 0; req_write1 = 0; req_addr1 = 0; req_wdata1 = 0; rsp_ready1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_req_ready1", req_ready1, 1);
        rst_n = 1;

        for (int i = 0; i < 12; i++) begin
            txn(tbl[i].w, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
                tbl[i].exp_rd, tbl[i].exp_err);
            if (tbl[i].w && !tbl[i].exp_err) model[int'(tbl[i].addr / 8)] = tbl[i].wdata;
        end

        // Reset during WAIT must drop the pending store
        req_valid = 1; req_write = 1; req_addr = 64'h20; req_wdata = 64'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        chk("abort_in_wait_ready", req_ready, 0);
        chk("abort_in_wait_valid", rsp_valid, 0);
        rst_n = 0;
        #1;
        chk("abort_rst_ready", req_ready, 1);
        chk("abort_rst_valid", rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        txn(0, 64'h20, 64'd0, 0, 64'd0, 0);

        // LATENCY=1: back-to-back loads alternate accept / response
        acc = 0;
        req_valid1 = 1; req_write1 = 0; req_addr1 = 64'h0; rsp_ready1 = 1;
        for (int k = 0; k < 10; k++) begin
            chk("l1_req_ready", req_ready1, (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("l1_rsp_valid", rsp_valid1, (k % 2 == 1) ? 64'd1 : 64'd0);
            if (rsp_valid1) begin
                chk("l1_rdata", rsp_rdata1, 0);
                chk("l1_err", rsp_err1, 0);
            end
            if (req_valid1 && req_ready1) acc++;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid1 = 0;
        chk("l1_accepts", acc, 5);

        for (int i = 0; i < 60; i++) begin
            int sel = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom};
            if (sel == 0) begin
                a = 64'($urandom_range(0, 15) * 8 + $urandom_range(1, 7));
            end else if (sel == 1) begin
                a = {$urandom, $urandom};
                if (a < 64'h800) a = a | 64'h800;
            end else if (sel == 2) begin
                a = 64'($urandom_range(DEPTH - 4, DEPTH - 1) * 8);
            end else begin
                a = 64'($urandom_range(0, 15) * 8);
            end
            run_model(w, a, d, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
